block_mac_2x2: RTL and testbench

- Computes one 2x2 block product C = A x B for the matrix-multiply datapath.
- Sits directly downstream of the matrix-multiply control unit, which drives start_mac and a_11..b_22.
- The control unit samples done_mac and c_11..c_22 and forwards them to the block accumulator.
- Uses a single time-shared multiplier over 8 steps. Operands are latched at start, so the control unit may prefetch the next block's operands while this block computes.

---
 rtl/block_mac_2x2_if.sv | 21 ++
 rtl/block_mac_2x2.sv | 111 +++++++++++
 tb/tb_block_mac_2x2.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/block_mac_2x2_if.sv
// Operand, start and result bundle shared by the matrix-multiply control unit and the 2x2 block MAC.
interface block_mac_2x2_if #(
    parameter int unsigned data_w = 32
);
    logic              start_mac;
    logic [data_w-1:0] a_11, a_12, a_21, a_22;
    logic [data_w-1:0] b_11, b_12, b_21, b_22;
    logic [data_w-1:0] c_11, c_12, c_21, c_22;
    logic              done_mac;
    logic              busy;

    modport master (
        output start_mac, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
        input  c_11, c_12, c_21, c_22, done_mac, busy
    );

    modport slave (
        input  start_mac, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
        output c_11, c_12, c_21, c_22, done_mac, busy
    );
endinterface

// File: rtl/block_mac_2x2.sv
// 2x2 block matrix product C = A x B using one time-shared multiplier over 8 steps.
// Operands are latched at start; results appear together with a one-cycle done pulse.
module block_mac_2x2 #(
    parameter int unsigned data_w = 32
) (
    input  logic            clk,
    input  logic            rst,
    block_mac_2x2_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMul, StLast} state_e;

    // Packed block index: 0 = x11, 1 = x12, 2 = x21, 3 = x22.
    typedef logic [3:0][data_w-1:0] blk_t;

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;
    blk_t              a_q, a_d, b_q, b_d;
    blk_t              sum_q, sum_d;
    blk_t              c_q, c_d;
    logic [data_w-1:0] prod_q, prod_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [data_w-1:0] op_x, op_y;
    logic [2:0]        prev_step;

    // Step s multiplies a[row(s), k(s)] by b[k(s), col(s)] with row=s[2], col=s[1], k=s[0].
    assign op_x      = a_q[{step_q[2], step_q[0]}];
    assign op_y      = b_q[{step_q[0], step_q[1]}];
    assign prev_step = step_q - 3'd1;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_mac) begin
                    a_d     = {bus.a_22, bus.a_21, bus.a_12, bus.a_11};
                    b_d     = {bus.b_22, bus.b_21, bus.b_12, bus.b_11};
                    sum_d   = '0;
                    step_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StMul;
                end
            end
            StMul: begin
                prod_d = op_x * op_y;
                // The product registered on the previous step lands in its target sum now.
                if (step_q != 3'd0) begin
                    sum_d[prev_step[2:1]] = sum_q[prev_step[2:1]] + prod_q;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d = StLast;
                end
            end
            StLast: begin
                sum_d[3] = sum_q[3] + prod_q;
                c_d      = sum_d;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                step_d   = 3'd0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.c_11     = c_q[0];
    assign bus.c_12     = c_q[1];
    assign bus.c_21     = c_q[2];
    assign bus.c_22     = c_q[3];
    assign bus.done_mac = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_block_mac_2x2.sv
// Self-checking bench for block_mac_2x2: directed table, corner sequences and random ops vs a matrix model.
module tb_block_mac_2x2;

    localparam int unsigned W = 32;

    typedef logic [3:0][W-1:0] blk_t;  // 0 = x11, 1 = x12, 2 = x21, 3 = x22

    typedef struct {
        blk_t a;
        blk_t b;
        blk_t c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_mac_2x2_if #(.data_w(W)) bus ();

    block_mac_2x2 #(.data_w(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    blk_t prev_c;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain 2x2 matrix product, modulo 2^W.
    function automatic blk_t model(input blk_t a, input blk_t b);
        blk_t c;
        c[0] = a[0] * b[0] + a[1] * b[2];
        c[1] = a[0] * b[1] + a[1] * b[3];
        c[2] = a[2] * b[0] + a[3] * b[2];
        c[3] = a[2] * b[1] + a[3] * b[3];
        return c;
    endfunction

    task automatic drive(input blk_t a, input blk_t b);
        bus.a_11 = a[0]; bus.a_12 = a[1]; bus.a_21 = a[2]; bus.a_22 = a[3];
        bus.b_11 = b[0]; bus.b_12 = b[1]; bus.b_21 = b[2]; bus.b_22 = b[3];
    endtask

    task automatic read_c(output blk_t c);
        c = {bus.c_22, bus.c_21, bus.c_12, bus.c_11};
    endtask

    task automatic chk_blk(input string tag, input blk_t exp);
        blk_t got;
        read_c(got);
        chk({tag, " c_11"}, got[0], exp[0]);
        chk({tag, " c_12"}, got[1], exp[1]);
        chk({tag, " c_21"}, got[2], exp[2]);
        chk({tag, " c_22"}, got[3], exp[3]);
    endtask

    // Issues one operation and returns in the done_mac cycle (so a following call starts back-to-back).
    task automatic run_op(input string tag, input blk_t a, input blk_t b, input blk_t exp,
                          input bit scramble, input bit restart);
        blk_t got;
        blk_t junk;
        int   lat;
        bit   partial;
        junk = {4{W'(32'h55)}};
        drive(a, b);
        bus.start_mac = 1'b1;
        @(posedge clk); #1;
        bus.start_mac = 1'b0;
        if (scramble) drive(junk, junk);
        chk({tag, " busy after start"}, W'(bus.busy), W'(1));
        chk({tag, " done low after start"}, W'(bus.done_mac), W'(0));
        lat     = 0;
        partial = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (restart && cyc == 4) begin
                drive(b, a);
                bus.start_mac = 1'b1;
            end
            @(posedge clk); #1;
            if (restart && cyc == 4) bus.start_mac = 1'b0;
            if (bus.done_mac) begin
                lat = cyc;
                break;
            end
            read_c(got);
            if (got !== prev_c) partial = 1'b1;
        end
        chk({tag, " latency"}, W'(lat), W'(9));
        chk({tag, " c held before done"}, W'(partial), W'(0));
        chk({tag, " busy low at done"}, W'(bus.busy), W'(0));
        chk_blk(tag, exp);
        prev_c = exp;
    endtask

    initial begin
        vec_t vecs[5];
        blk_t a, b, ident, b_iso;
        int   n_done;

        vecs[0].a = {W'(4), W'(3), W'(2), W'(1)};
        vecs[0].b = {W'(8), W'(7), W'(6), W'(5)};
        vecs[0].c = {W'(50), W'(43), W'(22), W'(19)};
        vecs[1].a = {W'(1), W'(0), W'(0), W'(32'hFFFF_FFFF)};
        vecs[1].b = {W'(32'hFFFF_FFFF), W'(0), W'(0), W'(2)};
        vecs[1].c = {W'(32'hFFFF_FFFF), W'(0), W'(0), W'(32'hFFFF_FFFE)};
        vecs[2].a = {W'(32'hFFFF_FFFC), W'(3), W'(2), W'(32'hFFFF_FFFF)};
        vecs[2].b = {W'(8), W'(7), W'(6), W'(5)};
        vecs[2].c = {W'(32'hFFFF_FFF2), W'(32'hFFFF_FFF3), W'(10), W'(9)};
        vecs[3].a = '0;
        vecs[3].b = '0;
        vecs[3].c = '0;
        vecs[4].a = {W'(0), W'(0), W'(1), W'(32'h0001_0000)};
        vecs[4].b = {W'(0), W'(3), W'(0), W'(32'h0001_0000)};
        vecs[4].c = {W'(0), W'(0), W'(0), W'(3)};

        rst = 1'b0;
        bus.start_mac = 1'b0;
        drive('0, '0);
        prev_c = '0;
        #12;
        chk_blk("reset", '0);
        chk("reset done", W'(bus.done_mac), W'(0));
        chk("reset busy", W'(bus.busy), W'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table; consecutive calls also exercise back-to-back starts.
        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, 1'b0);
        end

        ident = {W'(1), W'(0), W'(0), W'(1)};
        b_iso = {W'(6), W'(7), W'(8), W'(9)};
        run_op("isolation", ident, b_iso, b_iso, 1'b1, 1'b0);

        // Second start at E4 must be ignored entirely.
        run_op("start while busy", vecs[0].a, vecs[0].b, vecs[0].c, 1'b0, 1'b1);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done_mac) n_done++;
        end
        chk("no second done", W'(n_done), W'(0));

        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
                b[k] = (i % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            end
            run_op($sformatf("rand%0d", i), a, b, model(a, b), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Asynchronous reset at step 5, away from any clock edge.
        drive(vecs[2].a, vecs[2].b);
        bus.start_mac = 1'b1;
        @(posedge clk); #1;
        bus.start_mac = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_blk("async reset", '0);
        chk("async reset done", W'(bus.done_mac), W'(0));
        chk("async reset busy", W'(bus.busy), W'(0));
        #2;
        rst = 1'b1;
        prev_c = '0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done_mac) n_done++;
        end
        chk("no done after reset", W'(n_done), W'(0));
        chk_blk("c cleared after reset", '0);

        run_op("after reset", vecs[0].a, vecs[0].b, vecs[0].c, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done one cycle", W'(bus.done_mac), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
